dcache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller for the MEM stage of the 5-stage MIPS pipeline.
- Sits between the EXMEM stage's data access (address, write data, MemRead, MemWrite) and a slow 256-bit-line backing memory with a request/ack handshake.
- On a miss it raises a stall that freezes PC, IFID, IDEX, EXMEM and MEMWB until the line is resident.

---
 rtl/dcache_controller.sv | 144 ++++++++++++++
 tb/tb_dcache_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage; misses stall the pipeline.
// Define DCACHE_STATS_EN to add saturating hit/miss counters (hit_count_o, miss_count_o).
module dcache_controller #(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 p1_req_i,
  input  logic                 p1_write_i,
  input  logic [31:0]          p1_addr_i,
  input  logic [31:0]          p1_data_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_count_o,
  output logic [31:0]          miss_count_o
`endif
);
  localparam int IDX      = $clog2(LINES);
  localparam int TAG_BITS = 32 - 5 - IDX;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;
  state_t state, state_n;

  logic [LINES-1:0]     valid_q, dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  logic [IDX-1:0]      idx;
  logic [TAG_BITS-1:0] req_tag;
  logic [2:0]          wsel;
  logic                hit, store_hit, fill;
  logic                stall, en, wr;
  logic [31:0]         addr;
  logic [LINE_BITS-1:0] wdata;
  logic                unused_addr_lsb;

  assign idx     = p1_addr_i[5 +: IDX];
  assign req_tag = p1_addr_i[31 -: TAG_BITS];
  assign wsel    = p1_addr_i[4:2];
  assign hit     = p1_req_i & valid_q[idx] & (tag_q[idx] == req_tag);
  assign unused_addr_lsb = ^p1_addr_i[1:0];

  always_comb begin
    state_n   = state;
    stall     = 1'b0;
    en        = 1'b0;
    wr        = 1'b0;
    addr      = '0;
    wdata     = '0;
    store_hit = 1'b0;
    fill      = 1'b0;
    case (state)
      IDLE: begin
        if (p1_req_i) begin
          if (hit) store_hit = p1_write_i;
          else begin
            stall   = 1'b1;
            state_n = (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        stall = 1'b1;
        en    = 1'b1;
        wr    = 1'b1;
        addr  = {tag_q[idx], idx, 5'b0};
        wdata = data_q[idx];
        if (mem_ack_i) state_n = ALLOCATE;
      end
      ALLOCATE: begin
        stall = 1'b1;
        en    = 1'b1;
        addr  = {req_tag, idx, 5'b0};
        if (mem_ack_i) begin
          fill    = 1'b1;
          state_n = REFILL;
        end
      end
      REFILL: begin
        // held request re-evaluates as a hit in IDLE next cycle
        stall   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign p1_stall_o   = !rst_i & stall;
  assign mem_enable_o = !rst_i & en;
  assign mem_write_o  = !rst_i & wr;
  assign mem_addr_o   = rst_i ? '0 : addr;
  assign mem_data_o   = rst_i ? '0 : wdata;
  assign p1_data_o    = (!rst_i && hit) ? data_q[idx][{wsel, 5'b0} +: 32] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state <= state_n;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (store_hit) dirty_q[idx] <= 1'b1;
    end
  end

  // tags and data are qualified by valid, so they carry no reset
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[idx]  <= req_tag;
      data_q[idx] <= mem_data_i;
    end
    if (store_hit) data_q[idx][{wsel, 5'b0} +: 32] <= p1_data_i;
  end

`ifdef DCACHE_STATS_EN
  logic post_refill_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      post_refill_q <= 1'b0;
      hit_count_o   <= '0;
      miss_count_o  <= '0;
    end else begin
      post_refill_q <= (state == REFILL);
      if (state == IDLE && hit && !post_refill_q && hit_count_o != '1)
        hit_count_o <= hit_count_o + 32'd1;
      if (state == IDLE && state_n != IDLE && miss_count_o != '1)
        miss_count_o <= miss_count_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench: flat architectural memory model plus abstract residency model versus the cache.
module tb_dcache_controller;
  logic         clk = 1'b0, rst = 1'b1;
  logic         p1_req = 1'b0, p1_write = 1'b0;
  logic [31:0]  p1_addr = '0, p1_wdata = '0;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o, mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i = '0;
  logic         mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count_o, miss_count_o;
`endif

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst),
    .p1_req_i(p1_req), .p1_write_i(p1_write), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack)
`ifdef DCACHE_STATS_EN
    , .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // backing memory as the DUT sees it, and the architectural word view the CPU must observe
  logic [255:0] bmem [int unsigned];
  logic [31:0]  arch [int unsigned];
  bit           mv [32], md [32];
  logic [21:0]  mt [32];
  int           m_hits = 0, m_misses = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [255:0] bline(input logic [31:0] la);
    logic [255:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = init_word(la + 32'(4*k));
    return l;
  endfunction

  function automatic logic [31:0] arch_word(input logic [31:0] a);
    logic [31:0]  wa;
    logic [255:0] l;
    wa = {a[31:2], 2'b00};
    if (arch.exists(wa)) return arch[wa];
    l = bline({a[31:5], 5'b0});
    return l[a[4:2]*32 +: 32];
  endfunction

  // memory responder: acks after `lat` enabled cycles and logs what it saw
  int           cnt = 0, lat = 3, n_wb = 0, n_al = 0, en_cyc = 0, unstable = 0;
  logic [31:0]  wb_addr = '0, al_addr = '0, h_addr = '0;
  logic [255:0] wb_line = '0, h_data = '0;
  logic         h_wr = 1'b0;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (rst || !mem_enable_o) cnt = 0;
    else begin
      if (cnt > 0 && (mem_addr_o !== h_addr || mem_write_o !== h_wr || mem_data_o !== h_data))
        unstable++;
      h_addr = mem_addr_o; h_wr = mem_write_o; h_data = mem_data_o;
      en_cyc++;
      cnt++;
      mem_data_i = bline(mem_addr_o);
      if (cnt >= lat) begin
        mem_ack = 1'b1;
        cnt = 0;
        if (mem_write_o) begin
          n_wb++; wb_addr = mem_addr_o; wb_line = mem_data_o;
          bmem[mem_addr_o] = mem_data_o;
        end else begin
          n_al++; al_addr = mem_addr_o;
        end
      end
    end
  end

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rd);
    int           ix, exp_st, exp_en;
    logic [21:0]  tg;
    bit           hit, dmiss;
    logic [31:0]  victim;
    logic [255:0] vline;
    ix = int'(a[9:5]); tg = a[31:10];
    hit = mv[ix] && mt[ix] == tg;
    dmiss = !hit && mv[ix] && md[ix];
    victim = {mt[ix], a[9:5], 5'b0};
    for (int k = 0; k < 8; k++) vline[k*32 +: 32] = arch_word(victim + 32'(4*k));
    exp_en = hit ? 0 : (dmiss ? 2*lat : lat);
    exp_st = hit ? 0 : exp_en + 2;
    n_wb = 0; n_al = 0; en_cyc = 0;
    @(posedge clk); #1;
    p1_req = 1'b1; p1_write = wr; p1_addr = a; p1_wdata = d;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!p1_stall_o) break;
      stalls++;
      if (stalls > 100) begin chk("stall_timeout", 1, 0); break; end
    end
    rd = p1_data_o;
    chk("stall_cycles", stalls, exp_st);
    chk("mem_busy_cycles", en_cyc, exp_en);
    if (!wr) chk("load_data", rd, arch_word(a));
    chk("wb_count", n_wb, dmiss ? 1 : 0);
    if (dmiss) begin
      chk("wb_addr", wb_addr, victim);
      chk("wb_line", wb_line, vline);
    end
    chk("alloc_count", n_al, hit ? 0 : 1);
    if (!hit) chk("alloc_addr", al_addr, {a[31:5], 5'b0});
    if (wr) arch[{a[31:2], 2'b00}] = d;
    if (hit) m_hits++;
    else begin
      m_misses++;
      mv[ix] = 1'b1; mt[ix] = tg; md[ix] = 1'b0;
    end
    if (wr) md[ix] = 1'b1;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    p1_req = 1'b0;
  endtask

  int           st;
  logic [31:0]  rd, ra;
  logic [255:0] pre;
  initial begin
    for (int k = 0; k < 8; k++) pre[k*32 +: 32] = 32'h1234_5678 + 32'(k) * 32'h1111_1111;
    bmem[32'h40] = pre;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_enable", mem_enable_o, 0);
    chk("reset_stall", p1_stall_o, 0);
    chk("reset_addr", mem_addr_o, 0);
    chk("reset_rdata", p1_data_o, 0);

    lat = 3;
    access(0, 32'h40, 0, st, rd);
    chk("first_load_word0", rd, 32'h1234_5678);
    chk("first_load_stall", st, 5);
    chk("first_alloc_addr", al_addr, 32'h40);
    access(0, 32'h44, 0, st, rd);
    chk("hit_word1", rd, 32'h2345_6789);
    chk("hit_no_stall", st, 0);
    access(1, 32'h48, 32'hDEAD_BEEF, st, rd);
    access(0, 32'h48, 0, st, rd);
    chk("store_then_load", rd, 32'hDEAD_BEEF);
    access(0, 32'h448, 0, st, rd);
    chk("dirty_wb_addr", wb_addr, 32'h40);
    ra = wb_line[95:64];
    chk("dirty_wb_word2", ra, 32'hDEAD_BEEF);
    chk("dirty_alloc_addr", al_addr, 32'h440);
    chk("dirty_stall", st, 8);
    access(0, 32'h840, 0, st, rd);
    chk("clean_conflict_wb", n_wb, 0);
    chk("clean_conflict_stall", st, 5);
`ifdef DCACHE_STATS_EN
    chk("stats_hits", hit_count_o, 3);
    chk("stats_misses", miss_count_o, 3);
`endif

    // reset while ALLOCATE is waiting on a slow memory
    lat = 6;
    @(posedge clk); #1;
    p1_req = 1'b1; p1_write = 1'b0; p1_addr = 32'h40;
    repeat (3) @(negedge clk);
    chk("pre_reset_enable", mem_enable_o, 1);
    @(posedge clk); #1;
    rst = 1'b1; p1_req = 1'b0;
    @(negedge clk);
    chk("in_reset_enable", mem_enable_o, 0);
    chk("in_reset_stall", p1_stall_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_enable", mem_enable_o, 0);
    chk("post_reset_stall", p1_stall_o, 0);
`ifdef DCACHE_STATS_EN
    chk("stats_reset", {hit_count_o, miss_count_o}, 0);
`endif
    for (int i = 0; i < 32; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
    arch.delete();
    m_hits = 0; m_misses = 0;
    lat = 2;
    access(0, 32'h40, 0, st, rd);
    chk("post_reset_miss", st, 4);

    for (int i = 0; i < 400; i++) begin
      lat = int'($urandom_range(1, 4));
      ra = {20'b0, 2'($urandom_range(0, 3)), 3'b0, 2'($urandom_range(0, 3)), 3'($urandom), 2'b00};
      access(1'($urandom), ra, $urandom, st, rd);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    chk("mem_outputs_stable", unstable, 0);
`ifdef DCACHE_STATS_EN
    chk("stats_hits_final", hit_count_o, m_hits);
    chk("stats_misses_final", miss_count_o, m_misses);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
